// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if #(
  parameter int RET_W = 32
);
  logic [6:0]       Opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             ALUSrc;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic             Jump;
  logic             JumpR;
  logic [1:0]       MemtoReg;
  logic [1:0]       ALUOp;
  logic [2:0]       state;
  logic             trap;
  logic             illegal;
  logic             mem_err;
  logic [RET_W-1:0] retired;

  modport master (
    input  Opcode, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, ALUSrc, RegWrite, MemRead, MemWrite,
           Branch, Jump, JumpR, MemtoReg, ALUOp, state, trap, illegal, mem_err, retired
  );

  modport slave (
    output Opcode, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite, ALUSrc, RegWrite, MemRead, MemWrite,
           Branch, Jump, JumpR, MemtoReg, ALUOp, state, trap, illegal, mem_err, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with memory wait timeout and sticky fault flags.
// Define MCC_UTYPE_EN to make LUI/AUIPC legal (otherwise they trap in DECODE).
module multicycle_controller #(
  parameter int MAX_WAIT = 15,
  parameter int RET_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef struct packed {
    logic       mem_req, iord, ir_write, pc_write, alu_src, reg_write;
    logic       mem_read, mem_write, branch, jump, jump_r;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
  } ctl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

`ifdef MCC_UTYPE_EN
  localparam bit UTYPE_EN = 1'b1;
`else
  localparam bit UTYPE_EN = 1'b0;
`endif

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: return 1'b1;
      OP_LUI, OP_AUIPC:                                   return UTYPE_EN;
      default:                                            return 1'b0;
    endcase
  endfunction

  // Pure Moore decode; evaluated on the next state so the outputs can be registered.
  function automatic ctl_t decode(input state_t st, input logic [6:0] op);
    ctl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
      end
      DECODE: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      EXEC: begin
        case (op)
          OP_R:   c.alu_op = 2'b10;
          OP_IMM: begin
            c.alu_src = 1'b1;
            c.alu_op  = 2'b11;
          end
          OP_LW, OP_SW: c.alu_src = 1'b1;
          OP_BR: begin
            c.branch = 1'b1;
            c.alu_op = 2'b01;
          end
          OP_JAL: begin
            c.jump       = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.pc_write   = 1'b1;
          end
          OP_JALR: begin
            c.jump_r     = 1'b1;
            c.alu_src    = 1'b1;
            c.alu_op     = 2'b11;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.pc_write   = 1'b1;
          end
          OP_AUIPC: c.alu_src = UTYPE_EN;
          default:  ;
        endcase
      end
      MEM: begin
        c.mem_req   = 1'b1;
        c.iord      = 1'b1;
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
      end
      WB: begin
        c.reg_write = 1'b1;
        if (op == OP_LW)
          c.mem_to_reg = 2'b01;
        else if (UTYPE_EN && op == OP_LUI)
          c.mem_to_reg = 2'b11;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t           state_reg, state_next;
  logic [6:0]       opop_reg, opop_next;
  logic [7:0]       wait_reg, wait_next;
  logic [RET_W-1:0] retired_reg, retired_next;
  logic             illegal_reg, illegal_next;
  logic             mem_err_reg, mem_err_next;
  logic             trap_reg;
  ctl_t             ctl_reg;

  always_comb begin
    state_next   = state_reg;
    opop_next    = opop_reg;
    wait_next    = wait_reg;
    illegal_next = illegal_reg;
    mem_err_next = mem_err_reg;
    retired_next = retired_reg;
    case (state_reg)
      FETCH, MEM: begin
        // A completion in the last allowed cycle still wins over the timeout.
        if (bus.mem_ready) begin
          if (state_reg == FETCH)
            state_next = DECODE;
          else if (opop_reg == OP_SW)
            state_next = FETCH;
          else
            state_next = WB;
        end else if (wait_reg == WAIT_LAST) begin
          state_next   = TRAP;
          mem_err_next = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      DECODE: begin
        opop_next = bus.Opcode;
        if (op_legal(bus.Opcode)) begin
          state_next = EXEC;
        end else begin
          state_next   = TRAP;
          illegal_next = 1'b1;
        end
      end
      EXEC: begin
        case (opop_reg)
          OP_R, OP_IMM, OP_LUI, OP_AUIPC: state_next = WB;
          OP_LW, OP_SW:                   state_next = MEM;
          default:                        state_next = FETCH;
        endcase
      end
      WB:      state_next = FETCH;
      default: state_next = TRAP;
    endcase
    if ((state_next == FETCH || state_next == MEM) && state_next != state_reg)
      wait_next = '0;
    if (state_next == FETCH && (state_reg == EXEC || state_reg == MEM || state_reg == WB))
      retired_next = retired_reg + RET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= FETCH;
      opop_reg    <= '0;
      wait_reg    <= '0;
      retired_reg <= '0;
      illegal_reg <= 1'b0;
      mem_err_reg <= 1'b0;
      trap_reg    <= 1'b0;
      ctl_reg     <= decode(FETCH, 7'd0);
    end else begin
      state_reg   <= state_next;
      opop_reg    <= opop_next;
      wait_reg    <= wait_next;
      retired_reg <= retired_next;
      illegal_reg <= illegal_next;
      mem_err_reg <= mem_err_next;
      trap_reg    <= (state_next == TRAP);
      ctl_reg     <= decode(state_next, opop_next);
    end
  end

  assign bus.mem_req  = ctl_reg.mem_req;
  assign bus.IorD     = ctl_reg.iord;
  assign bus.IRWrite  = ctl_reg.ir_write;
  assign bus.PCWrite  = ctl_reg.pc_write;
  assign bus.ALUSrc   = ctl_reg.alu_src;
  assign bus.RegWrite = ctl_reg.reg_write;
  assign bus.MemRead  = ctl_reg.mem_read;
  assign bus.MemWrite = ctl_reg.mem_write;
  assign bus.Branch   = ctl_reg.branch;
  assign bus.Jump     = ctl_reg.jump;
  assign bus.JumpR    = ctl_reg.jump_r;
  assign bus.MemtoReg = ctl_reg.mem_to_reg;
  assign bus.ALUOp    = ctl_reg.alu_op;
  assign bus.state    = state_reg;
  assign bus.trap     = trap_reg;
  assign bus.illegal  = illegal_reg;
  assign bus.mem_err  = mem_err_reg;
  assign bus.retired  = retired_reg;
endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven, scoreboard-checked bench for multicycle_controller: per-cycle state,
// control word, retired count and fault flags.
module tb_multicycle_controller;
  localparam int RET_W    = 32;
  localparam int MAX_WAIT = 15;

  localparam logic [2:0] S_FETCH = 3'd0, S_DEC = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Control word bit order: mem_req IorD IRWrite PCWrite ALUSrc RegWrite MemRead MemWrite
  // Branch Jump JumpR, then MemtoReg, then ALUOp.
  function automatic logic [14:0] mk(input logic [10:0] en, input logic [1:0] m2r,
                                     input logic [1:0] aop);
    return {en, m2r, aop};
  endfunction

  localparam logic [14:0] CW_NONE    = 15'd0;
  localparam logic [14:0] CW_FETCH   = mk(11'b10000010000, 2'b00, 2'b00);
  localparam logic [14:0] CW_DEC     = mk(11'b00110000000, 2'b00, 2'b00);
  localparam logic [14:0] CW_R_EX    = mk(11'b00000000000, 2'b00, 2'b10);
  localparam logic [14:0] CW_I_EX    = mk(11'b00001000000, 2'b00, 2'b11);
  localparam logic [14:0] CW_LS_EX   = mk(11'b00001000000, 2'b00, 2'b00);
  localparam logic [14:0] CW_BR_EX   = mk(11'b00000000100, 2'b00, 2'b01);
  localparam logic [14:0] CW_JAL_EX  = mk(11'b00010100010, 2'b10, 2'b00);
  localparam logic [14:0] CW_JALR_EX = mk(11'b00011100001, 2'b10, 2'b11);
  localparam logic [14:0] CW_LW_MEM  = mk(11'b11000010000, 2'b00, 2'b00);
  localparam logic [14:0] CW_SW_MEM  = mk(11'b11000001000, 2'b00, 2'b00);
  localparam logic [14:0] CW_WB_ALU  = mk(11'b00000100000, 2'b00, 2'b00);
  localparam logic [14:0] CW_WB_MEM  = mk(11'b00000100000, 2'b01, 2'b00);
  localparam logic [14:0] CW_WB_LUI  = mk(11'b00000100000, 2'b11, 2'b00);

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [14:0] cw;
    logic [31:0] ret;
    logic [2:0] fl;   // {trap, illegal, mem_err}
  } exp_t;

  typedef struct {
    string       name;
    logic [6:0]  op;
    int          fw;
    int          mw;
    bit          has_mem;
    bit          has_wb;
    logic [14:0] ex_cw;
    logic [14:0] mem_cw;
    logic [14:0] wb_cw;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [31:0] ret_exp;
  exp_t sb[$];
  vec_t vecs[$];

  multicycle_controller_if #(.RET_W(RET_W)) bus ();

  multicycle_controller #(.MAX_WAIT(MAX_WAIT), .RET_W(RET_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [14:0] acw;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      acw = {bus.mem_req, bus.IorD, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.RegWrite,
             bus.MemRead, bus.MemWrite, bus.Branch, bus.Jump, bus.JumpR, bus.MemtoReg, bus.ALUOp};
      checks++;
      if ({bus.state, acw, bus.retired, bus.trap, bus.illegal, bus.mem_err} !== {e.st, e.cw, e.ret, e.fl}) begin
        errors++;
        $display("FAIL cyc%0d %s: got st=%0d cw=%b ret=%0d fl=%b, required st=%0d cw=%b ret=%0d fl=%b",
                 cycle, e.tag, bus.state, acw, bus.retired, {bus.trap, bus.illegal, bus.mem_err},
                 e.st, e.cw, e.ret, e.fl);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] cw, input logic [2:0] fl);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.cw  = cw;
    e.ret = ret_exp;
    e.fl  = fl;
    sb.push_back(e);
    tick();
  endtask

  task automatic reset_from(input string tag, input logic [2:0] st, input logic [14:0] cw, input logic [2:0] fl);
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    cyc(tag, st, cw, fl);
    reset_n = 1'b1;
    ret_exp = '0;
  endtask

  task automatic run_vec(input vec_t v);
    $display("instr %s op=%b fetch_wait=%0d mem_wait=%0d retired_before=%0d", v.name, v.op, v.fw, v.mw, ret_exp);
    bus.Opcode = v.op;
    for (int i = 0; i <= v.fw; i++) begin
      bus.mem_ready = (i == v.fw);
      cyc({v.name, "/fetch"}, S_FETCH, CW_FETCH, 3'b000);
    end
    bus.mem_ready = 1'($urandom_range(0, 1));
    cyc({v.name, "/decode"}, S_DEC, CW_DEC, 3'b000);
    bus.Opcode = 7'($urandom_range(0, 127));
    bus.mem_ready = 1'($urandom_range(0, 1));
    cyc({v.name, "/exec"}, S_EXEC, v.ex_cw, 3'b000);
    if (v.has_mem) begin
      for (int i = 0; i <= v.mw; i++) begin
        bus.mem_ready = (i == v.mw);
        cyc({v.name, "/mem"}, S_MEM, v.mem_cw, 3'b000);
      end
    end
    if (v.has_wb) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc({v.name, "/wb"}, S_WB, v.wb_cw, 3'b000);
    end
    ret_exp = ret_exp + 32'd1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic seq_illegal(input string tag, input logic [6:0] op);
    $display("instr %s op=%b expect illegal trap", tag, op);
    bus.Opcode = op;
    bus.mem_ready = 1'b1;
    cyc({tag, "/fetch"}, S_FETCH, CW_FETCH, 3'b000);
    bus.mem_ready = 1'b0;
    cyc({tag, "/decode"}, S_DEC, CW_DEC, 3'b000);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc({tag, "/trap"}, S_TRAP, CW_NONE, 3'b110);
    end
    reset_from({tag, "/trap_rst"}, S_TRAP, CW_NONE, 3'b110);
    cyc({tag, "/cleared"}, S_FETCH, CW_FETCH, 3'b000);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Opcode = '0;
    ret_exp = '0;

    vecs.push_back('{"R",     OP_R,    0,  0,  1'b0, 1'b1, CW_R_EX,    CW_NONE,   CW_WB_ALU});
    vecs.push_back('{"SW",    OP_SW,   0,  0,  1'b1, 1'b0, CW_LS_EX,   CW_SW_MEM, CW_NONE});
    vecs.push_back('{"BEQ",   OP_BR,   0,  0,  1'b0, 1'b0, CW_BR_EX,   CW_NONE,   CW_NONE});
    vecs.push_back('{"LW",    OP_LW,   3,  3,  1'b1, 1'b1, CW_LS_EX,   CW_LW_MEM, CW_WB_MEM});
    vecs.push_back('{"IMM",   OP_IMM,  1,  0,  1'b0, 1'b1, CW_I_EX,    CW_NONE,   CW_WB_ALU});
    vecs.push_back('{"JAL",   OP_JAL,  2,  0,  1'b0, 1'b0, CW_JAL_EX,  CW_NONE,   CW_NONE});
    vecs.push_back('{"JALR",  OP_JALR, 0,  0,  1'b0, 1'b0, CW_JALR_EX, CW_NONE,   CW_NONE});
    vecs.push_back('{"SW2",   OP_SW,   2,  5,  1'b1, 1'b0, CW_LS_EX,   CW_SW_MEM, CW_NONE});
    vecs.push_back('{"LWmax", OP_LW,   14, 14, 1'b1, 1'b1, CW_LS_EX,   CW_LW_MEM, CW_WB_MEM});
    vecs.push_back('{"Rmax",  OP_R,    14, 0,  1'b0, 1'b1, CW_R_EX,    CW_NONE,   CW_WB_ALU});
`ifdef MCC_UTYPE_EN
    vecs.push_back('{"LUI",   OP_LUI,  0,  0,  1'b0, 1'b1, CW_NONE,    CW_NONE,   CW_WB_LUI});
    vecs.push_back('{"AUIPC", OP_AUIPC,1,  0,  1'b0, 1'b1, CW_LS_EX,   CW_NONE,   CW_WB_ALU});
`endif

    tick();
    cyc("reset", S_FETCH, CW_FETCH, 3'b000);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    seq_illegal("ill_7f", 7'b1111111);
`ifndef MCC_UTYPE_EN
    seq_illegal("ill_lui", OP_LUI);
    seq_illegal("ill_auipc", OP_AUIPC);
`endif

    $display("instr timeout_fetch mem_ready held low");
    bus.Opcode = OP_R;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < MAX_WAIT - 1; i++) cyc("to_fetch/wait", S_FETCH, CW_FETCH, 3'b000);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc("to_fetch/trap", S_TRAP, CW_NONE, 3'b101);
    end
    reset_from("to_fetch/rst", S_TRAP, CW_NONE, 3'b101);

    $display("instr timeout_mem LW with mem_ready held low in MEM");
    bus.Opcode = OP_LW;
    bus.mem_ready = 1'b1;
    cyc("to_mem/fetch", S_FETCH, CW_FETCH, 3'b000);
    bus.mem_ready = 1'b0;
    cyc("to_mem/decode", S_DEC, CW_DEC, 3'b000);
    cyc("to_mem/exec", S_EXEC, CW_LS_EX, 3'b000);
    for (int i = 0; i < MAX_WAIT; i++) cyc("to_mem/wait", S_MEM, CW_LW_MEM, 3'b000);
    for (int i = 0; i < 3; i++) cyc("to_mem/trap", S_TRAP, CW_NONE, 3'b101);
    reset_from("to_mem/rst", S_TRAP, CW_NONE, 3'b101);

    run_vec(vecs[0]);
    $display("instr SW with reset during MEM");
    bus.Opcode = OP_SW;
    bus.mem_ready = 1'b1;
    cyc("sw_rst/fetch", S_FETCH, CW_FETCH, 3'b000);
    bus.mem_ready = 1'b0;
    cyc("sw_rst/decode", S_DEC, CW_DEC, 3'b000);
    cyc("sw_rst/exec", S_EXEC, CW_LS_EX, 3'b000);
    reset_from("sw_rst/mem", S_MEM, CW_SW_MEM, 3'b000);
    cyc("sw_rst/after", S_FETCH, CW_FETCH, 3'b000);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory wait-cycle limit before a timeout trap, legal range 1..255.
REQ-002 Parameter RET_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 Opcode  input  7  opcode field of the instruction register; sampled only in FETCH and DECODE.
REQ-006 mem_ready  input  1  memory completion strobe for the current request.
REQ-007 mem_req  output  1  memory request held high while waiting in FETCH or MEM.
REQ-008 IorD  output  1  memory address select: 0 = PC (instruction), 1 = ALU result (data).
REQ-009 IRWrite, PCWrite  output  1 each  instruction-register and PC write enables, one-cycle pulses.
REQ-010 ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump, JumpR  output  1 each  same meanings as the single-cycle controller's signals, qualified by state.
REQ-011 MemtoReg  output  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (see Configuration).
REQ-012 ALUOp  output  2  00 LW/SW address, 01 branch, 10 R-type, 11 I-type/JALR.
REQ-013 state  output  3  current FSM state encoding, for debug.
REQ-014 trap, illegal, mem_err  output  1 each  sticky fault flags.
REQ-015 retired  output  RET_W  count of completed instructions.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; all outputs are decoded from state and the latched opcode (Moore-style, no combinational path from mem_ready to any output).
REQ-017 FETCH: mem_req=1, MemRead=1, IorD=0; when mem_ready=1, pulse IRWrite=1 and PCWrite=1, then go to DECODE.
REQ-018 DECODE: latch Opcode into opop_q; a supported opcode goes to EXEC; any other opcode goes to TRAP and sets illegal.
REQ-019 EXEC, R-type (0110011) or IMM (0010011): drive ALUOp 10 or 11, with ALUSrc=1 for IMM; then go to WB.
REQ-020 EXEC, LW (0000011) or SW (0100011): ALUOp=00, ALUSrc=1; then go to MEM.
REQ-021 EXEC, BR (1100011): ALUOp=01, Branch=1, one cycle; then go to FETCH.
REQ-022 EXEC, JAL (1101111) or JALR (1100111): pulse Jump or JumpR (JALR also drives ALUSrc=1 and ALUOp=11), RegWrite=1, MemtoReg=10, PCWrite=1; then go to FETCH.
REQ-023 MEM: mem_req=1, IorD=1, MemRead=1 for LW or MemWrite=1 for SW; on mem_ready, SW goes to FETCH and LW goes to WB.
REQ-024 WB: RegWrite=1 for one cycle, MemtoReg=01 for LW and 00 otherwise; then go to FETCH.
REQ-025 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle that mem_ready=0; on reaching MAX_WAIT, go to TRAP and set mem_err; mem_ready in the same cycle takes priority.
REQ-026 retired SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, wrapping modulo 2^RET_W.
REQ-027 TRAP is absorbing: all enables are 0, trap=1, and only reset exits it.
REQ-028 A mem_ready arriving outside FETCH or MEM SHALL be ignored.

Reset
REQ-029 With reset_n=0 at a clock edge: state=FETCH, retired=0, wait counter=0, opop_q=0, and trap, illegal and mem_err cleared; this applies mid-instruction as well, and no write enable asserts in the reset cycle.
REQ-030 In the first cycle after reset release, the controller SHALL be in FETCH with mem_req=1.

Configuration
REQ-031 Macro MCC_UTYPE_EN defined: LUI (0110111) and AUIPC (0010111) are legal; LUI goes EXEC->WB with MemtoReg=11, and AUIPC goes EXEC (ALUSrc=1, ALUOp=00) ->WB with MemtoReg=00.
REQ-032 Macro MCC_UTYPE_EN undefined: LUI and AUIPC are illegal and trap in DECODE, and MemtoReg never takes the value 11.

Verification
REQ-033 R-type 0110011 with mem_ready=1 immediately -> states 0,1,2,4,0; RegWrite high only in WB; retired goes 0->1.
REQ-034 LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles in each; WB has MemtoReg=01; retired=1.
REQ-035 SW then BEQ -> MemWrite is a single cycle in MEM, the SW sequence skips WB, Branch is high only in EXEC of BEQ, and retired=2.
REQ-036 Opcode 1111111 -> TRAP by the third cycle, illegal=1, all enables 0 for the following 20 cycles; reset_n low for one edge clears all flags.
REQ-037 mem_ready held at 0 with MAX_WAIT=15 -> TRAP after 15 wait cycles with mem_err=1 and mem_req=0 from then on.
REQ-038 reset_n asserted during MEM of a SW -> MemWrite=0 from that edge, state=FETCH, retired=0.
